bin2bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock.
- Generalises the fixed 4-bit combinational converter to any binary width W and digit count DIGITS.
- Uses valid/ready handshakes on both sides so it can sit between a binary datapath and a display or print stage that may stall.

---
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 tb/tb_bin2bcd_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter with valid/ready handshakes
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + W;
    localparam int CW = $clog2(W + 1);

    // DIGITS must be able to hold 2^W - 1; catch bad configurations at elaboration
    function automatic bit digits_ok();
        logic [127:0] p10;
        p10 = 128'd1;
        for (int i = 0; i < DIGITS; i++) begin
            p10 = p10 * 128'd10;
        end
        return (W >= 2) && (p10 >= (128'd1 << W));
    endfunction

    if (!digits_ok()) begin : g_cfg_check
        $error("bin2bcd_seq: DIGITS too small for W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [SW-1:0]  shreg;      // {BCD field, binary field}
    logic [BW-1:0]  adj;
    logic [SW-1:0]  shifted;

    // Ready only while idle and not held in reset
    assign in_ready = (state == IDLE) && !rst;

    // Add-3 correction on every digit >= 5, all digits in parallel on the pre-shift value
    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (shreg[W + 4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = shreg[W + 4*k +: 4] + 4'd3;
            end else begin
                adj[4*k +: 4] = shreg[W + 4*k +: 4];
            end
        end
    end

    assign shifted = {adj, shreg[W-1:0]} << 1;

    // Control FSM plus datapath: load, W shift steps, then hold the result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            bcd       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= {{BW{1'b0}}, bin};
                        cnt   <= CW'(W);
                        state <= CONV;
                    end
                end
                CONV: begin
                    shreg <= shifted;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd       <= shifted[SW-1:W];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq at W=8, W=4 and W=16
module tb_bin2bcd_seq;

    logic clk;
    logic rst;

    // W=8, DIGITS=3
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  bin8;
    logic [11:0] bcd8;
    // W=4, DIGITS=2
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  bin4;
    logic [7:0]  bcd4;
    // W=16, DIGITS=5
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] bin16;
    logic [19:0] bcd16;

    int tests;
    int fails;

    bin2bcd_seq #(.W(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .bin(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8), .bcd(bcd8)
    );

    bin2bcd_seq #(.W(4), .DIGITS(2)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4), .bcd(bcd4)
    );

    bin2bcd_seq #(.W(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .bin(bin16),
        .out_valid(out_valid16), .out_ready(out_ready16), .bcd(bcd16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] exp;
    } vec8_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic nibbles_ok(input logic [19:0] v);
        for (int k = 0; k < 5; k++) begin
            if (v[4*k +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One full W=8 transaction with out_ready=1: latency, busy window, result, return to IDLE
    task automatic run8(input logic [7:0] b, input logic [11:0] exp, input string tag);
        int  lat;
        logic busy_ok;
        in_valid8 = 1'b1;
        bin8 = b;
        lat = 0;
        while (!in_ready8 && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, " in_ready before accept"}, 32'(in_ready8), 32'd1);
        tick();
        in_valid8 = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid8 && lat < 50) begin
            if (in_ready8) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (in_ready8) busy_ok = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'd9);
        check({tag, " in_ready low while busy"}, 32'(busy_ok), 32'd1);
        check({tag, " bcd"}, 32'(bcd8), 32'(exp));
        check({tag, " nibbles <= 9"}, 32'(nibbles_ok(20'(bcd8))), 32'd1);
        tick();
        check({tag, " out_valid drops"}, 32'(out_valid8), 32'd0);
        check({tag, " in_ready returns"}, 32'(in_ready8), 32'd1);
        check({tag, " bcd held after handshake"}, 32'(bcd8), 32'(exp));
    endtask

    task automatic run4(input logic [3:0] b);
        int lat;
        logic [7:0] exp;
        exp = {4'(b / 10), 4'(b % 10)};
        in_valid4 = 1'b1;
        bin4 = b;
        lat = 0;
        while (!in_ready4 && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 30) begin
            tick();
            lat++;
        end
        check($sformatf("w4 bin=%0d latency", b), 32'(lat), 32'd5);
        check($sformatf("w4 bin=%0d bcd", b), 32'(bcd4), 32'(exp));
        tick();
    endtask

    task automatic run16(input logic [15:0] b, input logic [19:0] exp, input string tag);
        int lat;
        in_valid16 = 1'b1;
        bin16 = b;
        lat = 0;
        while (!in_ready16 && lat < 30) begin
            tick();
            lat++;
        end
        tick();
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd17);
        check({tag, " bcd"}, 32'(bcd16), 32'(exp));
        tick();
    endtask

    initial begin
        vec8_t      vecs[10];
        logic [7:0]  seq_bin[5];
        logic [11:0] seq_exp[5];
        int          acc_cyc[5];
        int          idx_in, idx_out, cyc, lat;
        logic        acc, hold_ok, stray;

        tests = 0;
        fails = 0;

        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd1,   12'h001};
        vecs[2] = '{8'd9,   12'h009};
        vecs[3] = '{8'd10,  12'h010};
        vecs[4] = '{8'd99,  12'h099};
        vecs[5] = '{8'd100, 12'h100};
        vecs[6] = '{8'd128, 12'h128};
        vecs[7] = '{8'd173, 12'h173};
        vecs[8] = '{8'd200, 12'h200};
        vecs[9] = '{8'd254, 12'h254};

        in_valid8 = 0; bin8 = 0; out_ready8 = 1;
        in_valid4 = 0; bin4 = 0; out_ready4 = 1;
        in_valid16 = 0; bin16 = 0; out_ready16 = 1;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("reset in_ready", 32'(in_ready8), 32'd0);
        check("reset out_valid", 32'(out_valid8), 32'd0);
        check("reset bcd", 32'(bcd8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle in_ready after release", 32'(in_ready8), 32'd1);
        check("idle out_valid after release", 32'(out_valid8), 32'd0);

        // Maximum value first
        run8(8'd255, 12'h255, "w8 max 255");

        // Table-driven single transactions
        for (int i = 0; i < 10; i++) begin
            run8(vecs[i].bin, vecs[i].exp, $sformatf("w8 vec%0d", i));
        end

        // Back-to-back with in_valid held high: results in order, accepts W+2 apart
        seq_bin[0] = 8'd0;   seq_exp[0] = 12'h000;
        seq_bin[1] = 8'd1;   seq_exp[1] = 12'h001;
        seq_bin[2] = 8'd99;  seq_exp[2] = 12'h099;
        seq_bin[3] = 8'd128; seq_exp[3] = 12'h128;
        seq_bin[4] = 8'd200; seq_exp[4] = 12'h200;
        idx_in = 0;
        idx_out = 0;
        in_valid8 = 1'b1;
        bin8 = seq_bin[0];
        out_ready8 = 1'b1;
        for (cyc = 0; cyc < 200 && idx_out < 5; cyc++) begin
            acc = in_valid8 && in_ready8;
            if (out_valid8) begin
                check($sformatf("b2b result %0d", idx_out), 32'(bcd8), 32'(seq_exp[idx_out]));
                check($sformatf("b2b nibbles %0d", idx_out), 32'(nibbles_ok(20'(bcd8))), 32'd1);
                idx_out++;
            end
            tick();
            if (acc) begin
                acc_cyc[idx_in] = cyc;
                idx_in++;
                if (idx_in < 5) bin8 = seq_bin[idx_in];
                else in_valid8 = 1'b0;
            end
        end
        in_valid8 = 1'b0;
        check("b2b all results seen", 32'(idx_out), 32'd5);
        check("b2b all accepted", 32'(idx_in), 32'd5);
        for (int i = 1; i < 5; i++) begin
            if (i < idx_in) begin
                check($sformatf("b2b accept spacing %0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd10);
            end
        end
        tick();

        // Backpressure: result held 20 cycles, competing operand not accepted meanwhile
        out_ready8 = 1'b0;
        in_valid8 = 1'b1;
        bin8 = 8'd173;
        lat = 0;
        while (!in_ready8 && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        bin8 = 8'd55;
        lat = 1;
        while (!out_valid8 && lat < 50) begin
            tick();
            lat++;
        end
        check("bp latency", 32'(lat), 32'd9);
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid8 || bcd8 !== 12'h173 || in_ready8) hold_ok = 1'b0;
            tick();
        end
        check("bp held 20 cycles", 32'(hold_ok), 32'd1);
        check("bp bcd", 32'(bcd8), 32'h173);
        out_ready8 = 1'b1;
        tick();
        check("bp single handshake", 32'(out_valid8), 32'd0);
        check("bp in_ready after release", 32'(in_ready8), 32'd1);
        tick();
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 50) begin
            tick();
            lat++;
        end
        check("bp next operand latency", 32'(lat), 32'd9);
        check("bp next operand bcd", 32'(bcd8), 32'h055);
        tick();

        // Asynchronous reset in the middle of a conversion
        in_valid8 = 1'b1;
        bin8 = 8'd77;
        tick();
        in_valid8 = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid reset out_valid", 32'(out_valid8), 32'd0);
        check("mid reset bcd", 32'(bcd8), 32'd0);
        check("mid reset in_ready", 32'(in_ready8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid8) stray = 1'b1;
        end
        check("mid reset no stray result", 32'(stray), 32'd0);
        run8(8'd42, 12'h042, "w8 after reset 42");

        // W=4 exhaustive
        for (int v = 0; v < 16; v++) begin
            run4(4'(v));
        end

        // W=16 corner values and random sweep against the reference
        run16(16'd65535, 20'h65535, "w16 max");
        run16(16'd10000, 20'h10000, "w16 10000");
        run16(16'd0, 20'h00000, "w16 zero");
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] r;
            r = 16'($urandom_range(0, 65535));
            run16(r, ref_bcd(32'(r)), $sformatf("w16 rnd %0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
